bram_uart_streamer: RTL and testbench

Sequences the read port of dual_port_block_ram into serial_tx, streaming a programmable window of RAM bytes over UART. Replaces the free-running divider/counter pacing with a handshake: each byte is read, handed to the transmitter only when it is idle, and the next read starts only after tx_done. Sits between a host-side start/config interface and the RAM read port plus serial_tx inputs.

---
 rtl/bram_stream_pkg.sv | 16 +
 rtl/bram_uart_streamer.sv | 133 +++++++++++++
 tb/tb_bram_uart_streamer.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_stream_pkg.sv
// Shared definitions for the BRAM-to-UART streamer: state encoding and default widths.
package bram_stream_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ      = 3'd1,
        WAIT_DATA = 3'd2,
        SEND      = 3'd3,
        WAIT_DONE = 3'd4,
        GAP       = 3'd5
    } state_t;

endpackage

// File: rtl/bram_uart_streamer.sv
// Streams a window of RAM bytes into a UART transmitter, one byte per tx_done handshake,
// with optional idle gap cycles between bytes.
module bram_uart_streamer
    import bram_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int GAP_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic                  ram_read_en,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  tx_dv,
    output logic [DATA_WIDTH-1:0] tx_byte,
    input  logic                  tx_active,
    input  logic                  tx_done,
    output state_t                dbg_state
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0]         GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [GW-1:0]         GAP_ONE  = GW'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   remaining;
    logic [GW-1:0]         gap_cnt;
    logic [ADDR_WIDTH-1:0] addr_next;

    // Natural overflow of the address register gives the wrap to zero.
    assign addr_next = addr + ADDR_ONE;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // Transmit handshake: tx_active low at an edge means the transmitter can take a byte;
    // tx_dv is then raised for exactly one cycle with tx_byte already stable, and the byte
    // counts as accepted in that cycle. Completion is only honoured via tx_done in WAIT_DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            done        <= 1'b0;
            tx_dv       <= 1'b0;
            ram_read_en <= 1'b0;
            ram_raddr   <= '0;
            tx_byte     <= '0;
            addr        <= '0;
            remaining   <= '0;
            gap_cnt     <= '0;
        end else begin
            done        <= 1'b0;
            ram_read_en <= 1'b0;
            tx_dv       <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                remaining <= '0;
                gap_cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (length == '0) begin
                                done <= 1'b1;
                            end else begin
                                addr        <= base_addr;
                                remaining   <= length;
                                ram_raddr   <= base_addr;
                                ram_read_en <= 1'b1;
                                state       <= READ;
                            end
                        end
                    end
                    READ: begin
                        state <= WAIT_DATA;
                    end
                    WAIT_DATA: begin
                        // Issue straight away when the transmitter is free, saving a cycle.
                        tx_byte <= ram_dout;
                        tx_dv   <= !tx_active;
                        state   <= SEND;
                    end
                    SEND: begin
                        if (tx_dv) begin
                            state <= WAIT_DONE;
                        end else if (!tx_active) begin
                            tx_dv <= 1'b1;
                        end
                    end
                    WAIT_DONE: begin
                        if (tx_done) begin
                            remaining <= remaining - CNT_ONE;
                            addr      <= addr_next;
                            if (remaining == CNT_ONE) begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end else if (GAP_CYCLES > 0) begin
                                gap_cnt <= '0;
                                state   <= GAP;
                            end else begin
                                ram_raddr   <= addr_next;
                                ram_read_en <= 1'b1;
                                state       <= READ;
                            end
                        end
                    end
                    GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            gap_cnt     <= '0;
                            ram_raddr   <= addr;
                            ram_read_en <= 1'b1;
                            state       <= READ;
                        end else begin
                            gap_cnt <= gap_cnt + GAP_ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bram_uart_streamer.sv
// Bench for bram_uart_streamer: RAM and serial_tx models, scoreboard of expected reads/bytes,
// directed steps for streaming, wrap, zero length, back-pressure, gap, abort and reset.
module tb_bram_uart_streamer;
    import bram_stream_pkg::*;

    localparam int DW     = 8;
    localparam int AW     = 10;
    localparam int TX_LEN = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start [2] = '{1'b0, 1'b0};
    logic          abort     = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length    = '0;
    logic          busy [2];
    logic          done [2];
    logic          ram_read_en [2];
    logic          tx_dv [2];
    logic [AW-1:0] ram_raddr [2];
    logic [DW-1:0] ram_dout [2];
    logic [DW-1:0] tx_byte [2];
    logic          tx_active [2] = '{1'b0, 1'b0};
    logic          tx_done [2]   = '{1'b0, 1'b0};
    state_t        dbg_state [2];

    logic [DW-1:0] mem [1 << AW];
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic hold_active = 1'b0;

    int   m_cnt [2]      = '{0, 0};
    logic m_busy [2]     = '{1'b0, 1'b0};
    int   dv_cnt [2]     = '{0, 0};
    int   rd_cnt [2]     = '{0, 0};
    int   done_cnt [2]   = '{0, 0};
    int   busy_cyc [2]   = '{0, 0};
    int   rd_cyc [2]     = '{0, 0};
    int   dv_cyc [2]     = '{0, 0};
    int   td_cyc [2]     = '{0, 0};
    logic td_pending [2] = '{1'b0, 1'b0};
    int   gap_diff [2]   = '{0, 0};

    bram_uart_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abort),
        .base_addr(base_addr), .length(length),
        .busy(busy[0]), .done(done[0]),
        .ram_raddr(ram_raddr[0]), .ram_read_en(ram_read_en[0]), .ram_dout(ram_dout[0]),
        .tx_dv(tx_dv[0]), .tx_byte(tx_byte[0]),
        .tx_active(tx_active[0]), .tx_done(tx_done[0]),
        .dbg_state(dbg_state[0])
    );

    bram_uart_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .GAP_CYCLES(5)) dut5 (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abort),
        .base_addr(base_addr), .length(length),
        .busy(busy[1]), .done(done[1]),
        .ram_raddr(ram_raddr[1]), .ram_read_en(ram_read_en[1]), .ram_dout(ram_dout[1]),
        .tx_dv(tx_dv[1]), .tx_byte(tx_byte[1]),
        .tx_active(tx_active[1]), .tx_done(tx_done[1]),
        .dbg_state(dbg_state[1])
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (ram_read_en[d]) ram_dout[d] <= mem[ram_raddr[d]];
        end
    end

    // serial_tx model plus scoreboard pops, evaluated on the falling edge
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_busy[d]    = 1'b0;
                m_cnt[d]     = 0;
                tx_done[d]   = 1'b0;
                tx_active[d] = 1'b0;
                td_pending[d] = 1'b0;
            end else begin
                tx_done[d] = 1'b0;
                if (busy[d]) busy_cyc[d]++;
                if (ram_read_en[d]) begin
                    rd_cnt[d]++;
                    if (td_pending[d]) begin
                        gap_diff[d]   = cyc - td_cyc[d];
                        td_pending[d] = 1'b0;
                    end
                    rd_cyc[d] = cyc;
                    total++;
                    if (exp_addr_q.size() == 0) begin
                        bad++;
                        $error("FAIL unexpected_read: dut=%0d observed addr=%0h required=none", d, ram_raddr[d]);
                    end else begin
                        logic [AW-1:0] ea;
                        ea = exp_addr_q.pop_front();
                        assert (ram_raddr[d] === ea) else begin
                            bad++;
                            $error("FAIL read_addr: dut=%0d observed=%0h required=%0h", d, ram_raddr[d], ea);
                        end
                    end
                end
                if (tx_dv[d]) begin
                    dv_cnt[d]++;
                    dv_cyc[d] = cyc;
                    total++;
                    assert (tx_active[d] === 1'b0) else begin
                        bad++;
                        $error("FAIL dv_while_active: dut=%0d observed tx_active=%0b required=0", d, tx_active[d]);
                    end
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $error("FAIL unexpected_byte: dut=%0d observed=%0h required=none", d, tx_byte[d]);
                    end else begin
                        logic [DW-1:0] eb;
                        eb = exp_q.pop_front();
                        assert (tx_byte[d] === eb) else begin
                            bad++;
                            $error("FAIL tx_byte: dut=%0d observed=%0h required=%0h", d, tx_byte[d], eb);
                        end
                    end
                    m_busy[d] = 1'b1;
                    m_cnt[d]  = TX_LEN;
                end else if (m_busy[d]) begin
                    m_cnt[d]--;
                    if (m_cnt[d] == 0) begin
                        m_busy[d]     = 1'b0;
                        tx_done[d]    = 1'b1;
                        td_cyc[d]     = cyc;
                        td_pending[d] = 1'b1;
                    end
                end
                if (done[d]) begin
                    done_cnt[d]++;
                    td_pending[d] = 1'b0;
                end
                tx_active[d] = m_busy[d] || (d == 0 && hold_active);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    task automatic kick(input int d, input logic [AW-1:0] b, input logic [AW:0] n);
        logic [AW-1:0] a;
        base_addr = b;
        length    = n;
        for (int i = 0; i < int'(n); i++) begin
            a = b + AW'(i);
            exp_addr_q.push_back(a);
            exp_q.push_back(mem[a]);
        end
        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int budget, input string tag);
        int n = 0;
        while (done[d] !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, {31'd0, done[d]}, 32'd1);
    endtask

    task automatic wait_dv(input int d, input int target, input int budget, input string tag);
        int n = 0;
        while (dv_cnt[d] < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, dv_cnt[d], target);
    endtask

    initial begin
        int dv0, rd0, dn0, by0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = i[DW-1:0];

        // reset state
        rst = 1'b1;
        tick(3);
        check("rst_busy", {31'd0, busy[0]}, 32'd0);
        check("rst_done", {31'd0, done[0]}, 32'd0);
        check("rst_tx_dv", {31'd0, tx_dv[0]}, 32'd0);
        check("rst_read_en", {31'd0, ram_read_en[0]}, 32'd0);
        check("rst_raddr", {22'd0, ram_raddr[0]}, 32'd0);
        check("rst_tx_byte", {24'd0, tx_byte[0]}, 32'd0);
        check("rst_state", {29'd0, dbg_state[0]}, {29'd0, IDLE});
        rst = 1'b0;
        tick(2);

        // 1: four bytes from 0x010
        dv0 = dv_cnt[0]; rd0 = rd_cnt[0]; dn0 = done_cnt[0];
        kick(0, 10'h010, 11'd4);
        check("t1_busy_up", {31'd0, busy[0]}, 32'd1);
        check("t1_read_first", {31'd0, ram_read_en[0]}, 32'd1);
        wait_done(0, 200, "t1_done_timeout");
        check("t1_busy_down", {31'd0, busy[0]}, 32'd0);
        check("t1_dv_count", dv_cnt[0] - dv0, 32'd4);
        check("t1_rd_count", rd_cnt[0] - rd0, 32'd4);
        check("t1_last_byte", {24'd0, tx_byte[0]}, 32'h13);
        check("t1_latency", dv_cyc[0] - rd_cyc[0], 32'd2);
        check("t1_gap0", gap_diff[0], 32'd1);
        tick();
        check("t1_done_pulse", {31'd0, done[0]}, 32'd0);
        check("t1_done_count", done_cnt[0] - dn0, 32'd1);
        check("t1_queue_empty", exp_q.size(), 32'd0);

        // 2: wrap across the top of RAM
        rd0 = rd_cnt[0];
        kick(0, 10'h3FE, 11'd3);
        wait_done(0, 200, "t2_done_timeout");
        check("t2_rd_count", rd_cnt[0] - rd0, 32'd3);
        check("t2_last_byte", {24'd0, tx_byte[0]}, 32'h00);
        check("t2_raddr_hold", {22'd0, ram_raddr[0]}, 32'h000);
        check("t2_addr_queue", exp_addr_q.size(), 32'd0);
        tick(2);

        // 3: zero length
        rd0 = rd_cnt[0]; by0 = busy_cyc[0]; dn0 = done_cnt[0];
        kick(0, 10'h055, 11'd0);
        check("t3_done_now", {31'd0, done[0]}, 32'd1);
        tick();
        check("t3_done_once", {31'd0, done[0]}, 32'd0);
        check("t3_done_count", done_cnt[0] - dn0, 32'd1);
        check("t3_no_busy", busy_cyc[0] - by0, 32'd0);
        check("t3_no_read", rd_cnt[0] - rd0, 32'd0);

        // 4: transmitter held busy, start while busy ignored
        hold_active = 1'b1;
        tick(2);
        dv0 = dv_cnt[0]; rd0 = rd_cnt[0];
        kick(0, 10'h020, 11'd1);
        tick(3);
        check("t4_in_send", {29'd0, dbg_state[0]}, {29'd0, SEND});
        tick(20);
        base_addr = 10'h200;
        length    = 11'd5;
        start[0]  = 1'b1;
        tick();
        start[0]  = 1'b0;
        tick(27);
        check("t4_dv_held", dv_cnt[0] - dv0, 32'd0);
        check("t4_still_send", {29'd0, dbg_state[0]}, {29'd0, SEND});
        hold_active = 1'b0;
        tick();
        check("t4_active_low", {31'd0, tx_active[0]}, 32'd0);
        check("t4_dv_not_yet", {31'd0, tx_dv[0]}, 32'd0);
        tick();
        check("t4_dv_pulse", {31'd0, tx_dv[0]}, 32'd1);
        wait_done(0, 200, "t4_done_timeout");
        check("t4_one_read", rd_cnt[0] - rd0, 32'd1);
        check("t4_byte", {24'd0, tx_byte[0]}, 32'h20);
        tick(3);
        check("t4_queue_empty", exp_q.size(), 32'd0);

        // 5: gap of five cycles on the second instance
        kick(1, 10'h040, 11'd3);
        wait_done(1, 300, "t5_done_timeout");
        check("t5_gap", gap_diff[1], 32'd6);
        check("t5_latency", dv_cyc[1] - rd_cyc[1], 32'd2);
        check("t5_last_byte", {24'd0, tx_byte[1]}, 32'h42);
        tick(2);

        // 6a: abort after the second byte
        dv0 = dv_cnt[0]; rd0 = rd_cnt[0]; dn0 = done_cnt[0];
        kick(0, 10'h080, 11'd8);
        wait_dv(0, dv0 + 2, 200, "t6_dv2_timeout");
        tick();
        check("t6_wait_done_state", {29'd0, dbg_state[0]}, {29'd0, WAIT_DONE});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t6_abort_idle", {29'd0, dbg_state[0]}, {29'd0, IDLE});
        check("t6_abort_busy", {31'd0, busy[0]}, 32'd0);
        exp_q.delete();
        exp_addr_q.delete();
        tick(12);
        check("t6_no_done", done_cnt[0] - dn0, 32'd0);
        check("t6_reads", rd_cnt[0] - rd0, 32'd2);
        kick(0, 10'h100, 11'd1);
        wait_done(0, 200, "t6_restart_timeout");
        check("t6_restart_byte", {24'd0, tx_byte[0]}, 32'h00);
        tick(2);

        // 6b: asynchronous reset in WAIT_DONE
        dv0 = dv_cnt[0]; dn0 = done_cnt[0];
        kick(0, 10'h005, 11'd3);
        wait_dv(0, dv0 + 1, 200, "t6r_dv_timeout");
        tick();
        check("t6r_state_pre", {29'd0, dbg_state[0]}, {29'd0, WAIT_DONE});
        rst = 1'b1;
        #1;
        check("t6r_state", {29'd0, dbg_state[0]}, {29'd0, IDLE});
        check("t6r_busy", {31'd0, busy[0]}, 32'd0);
        check("t6r_raddr", {22'd0, ram_raddr[0]}, 32'd0);
        check("t6r_tx_byte", {24'd0, tx_byte[0]}, 32'd0);
        check("t6r_tx_dv", {31'd0, tx_dv[0]}, 32'd0);
        check("t6r_done", {31'd0, done[0]}, 32'd0);
        tick(2);
        rst = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        tick(10);
        check("t6r_no_done", done_cnt[0] - dn0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
